page_game_grid: RTL and testbench

Parametrised successor renderer for the game page. It draws ROWS player rows of up to COLS_MAX digit cards, centred horizontally on a 640x480 raster, and tints the active and winning rows. It marks the cursor card and the selected card, and can blink the cursor. Game state is snapshotted once per frame so updates cannot tear the image. A three-stage pipeline hides the synchronous font-ROM latency. It sits between the game FSM and the VGA timing generator, which supplies x_pos, y_pos and the external font ROM.

---
 rtl/page_game_pkg.sv | 40 ++++
 rtl/page_game_if.sv | 44 ++++
 rtl/page_game_cell_locate.sv | 75 +++++++
 rtl/page_game_grid.sv | 185 ++++++++++++++++++
 tb/tb_page_game_grid.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/page_game_pkg.sv
// page_game_pkg: shared constants and types for the game-page grid renderer.
//   - Colour constants, {B,G,R} 4 bits each.
//   - Font ROM geometry: glyph pitch, ROM row length, glyph margin, border width.
//   - game_end encoding (0 = playing, w = row w-1 has won).
//   - Stage-2 payload struct carried from fetch to colour stage.
package page_game_pkg;

  localparam logic [11:0] BG     = 12'hfff;
  localparam logic [11:0] ACTIVE = 12'haaa;
  localparam logic [11:0] WIN    = 12'hff0;
  localparam logic [11:0] INK    = 12'h000;
  localparam logic [11:0] SEL    = 12'h0f0;
  localparam logic [11:0] CURSOR = 12'h00f;

  localparam int GLYPH_PITCH  = 32;   // ROM columns per glyph (one digit)
  localparam int ROM_ROW      = 320;  // ROM columns per glyph line (10 digits)
  localparam int GLYPH_MARGIN = 8;    // blank pixels each side of the glyph
  localparam int BORDER_W     = 4;    // cursor border thickness

  localparam int GE_PLAYING = 0;

  // game_end = row + 1 marks that row as the winner
  function automatic bit ge_row_won(input int ge, input int row);
    return ge == row + 1;
  endfunction

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  typedef struct packed {
    logic        vld;     // pipeline has been filled since reset
    logic        hit;     // pixel lies inside some card
    logic [11:0] bg;      // card background tint
    logic        ink_en;  // inside the glyph window with a printable digit
    logic [11:0] ink;     // ink colour if the ROM bit is set
    logic        cursor;  // draw cursor border here
  } stage2_t;

endpackage

// File: rtl/page_game_if.sv
// page_game_if: bundle between the game FSM / VGA timing generator (master)
// and the grid renderer (slave).
//   Raster:     x_pos, y_pos, frame_start
//   Game state: total_number, cur_player, status, selecting, cur_select,
//               selected, game_end
//   Font ROM:   font_addr (to ROM), font_data (from ROM, one cycle later)
//   Video:      pixel_data {B,G,R}
// There is no valid/ready handshake: the raster streams one coordinate per
// clock and pixel_data follows at a fixed three-cycle latency, frame_start
// is a one-cycle strobe and the ROM answers one cycle after each address.
interface page_game_if #(
  parameter int ROWS     = 2,
  parameter int COLS_MAX = 5
);
  localparam int TN_W = $clog2(COLS_MAX + 1);
  localparam int CP_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int GE_W = $clog2(ROWS + 1);

  logic [9:0]               x_pos;
  logic [9:0]               y_pos;
  logic                     frame_start;
  logic [TN_W-1:0]          total_number;
  logic [CP_W-1:0]          cur_player;
  logic [ROWS*COLS_MAX*4-1:0] status;
  logic                     selecting;
  logic [7:0]               cur_select;
  logic [7:0]               selected;
  logic [GE_W-1:0]          game_end;
  logic [14:0]              font_addr;
  logic                     font_data;
  logic [11:0]              pixel_data;

  modport master (
    output x_pos, y_pos, frame_start, total_number, cur_player, status,
           selecting, cur_select, selected, game_end, font_data,
    input  font_addr, pixel_data
  );

  modport slave (
    input  x_pos, y_pos, frame_start, total_number, cur_player, status,
           selecting, cur_select, selected, game_end, font_data,
    output font_addr, pixel_data
  );
endinterface

// File: rtl/page_game_cell_locate.sv
// page_game_cell_locate: combinational card search for one raster pixel.
//   x, y  : raster coordinate
//   n     : clamped card count per row (0 = no cards)
//   hit   : pixel is inside a card
//   row   : card row, col : card column
//   dx/dy : pixel offset inside the card
// Columns and rows are found with a parallel compare against each card's
// edges, so no divider is needed.
module page_game_cell_locate
  import page_game_pkg::*;
#(
  parameter int ROWS      = 2,
  parameter int COLS_MAX  = 5,
  parameter int CELL_W    = 80,
  parameter int CELL_H    = 128,
  parameter int ROW_Y0    = 150,
  parameter int ROW_PITCH = 180,
  localparam int TN_W = $clog2(COLS_MAX + 1),
  localparam int RW   = clog2_min1(ROWS),
  localparam int CW   = clog2_min1(COLS_MAX),
  localparam int DX_W = clog2_min1(CELL_W),
  localparam int DY_W = clog2_min1(CELL_H)
) (
  input  logic [9:0]      x,
  input  logic [9:0]      y,
  input  logic [TN_W-1:0] n,
  output logic            hit,
  output logic [RW-1:0]   row,
  output logic [CW-1:0]   col,
  output logic [DX_W-1:0] dx,
  output logic [DY_W-1:0] dy
);
  localparam int HALF_W = CELL_W / 2;
  localparam int X_MID  = 320;

  logic [11:0] x12, y12, left, lo, ytop;
  logic        hit_x, hit_y;

  // Cards are laid out from left = 320 - n*CELL_W/2; only the first n count.
  always_comb begin
    x12   = {2'b00, x};
    left  = 12'(X_MID - HALF_W * int'(n));
    lo    = '0;
    hit_x = 1'b0;
    col   = '0;
    dx    = '0;
    for (int c = 0; c < COLS_MAX; c++) begin
      lo = left + 12'(c * CELL_W);
      if ((c < int'(n)) && (x12 >= lo) && (x12 < lo + 12'(CELL_W))) begin
        hit_x = 1'b1;
        col   = CW'(c);
        dx    = DX_W'(x12 - lo);
      end
    end
  end

  always_comb begin
    y12   = {2'b00, y};
    ytop  = '0;
    hit_y = 1'b0;
    row   = '0;
    dy    = '0;
    for (int r = 0; r < ROWS; r++) begin
      ytop = 12'(ROW_Y0 + r * ROW_PITCH - CELL_H / 2);
      if ((y12 >= ytop) && (y12 < ytop + 12'(CELL_H))) begin
        hit_y = 1'b1;
        row   = RW'(r);
        dy    = DY_W'(y12 - ytop);
      end
    end
  end

  assign hit = hit_x & hit_y;

endmodule

// File: rtl/page_game_grid.sv
// page_game_grid: renders ROWS rows of up to COLS_MAX digit cards centred
// on a 640x480 raster, with active/winner row tints, selection ink and a
// cursor border.
//   vga_clk, vga_rst_n : pixel clock, asynchronous active-low reset
//   bus (slave)        : raster coordinates, frame_start, game state,
//                        font ROM address/data and pixel_data output
// Pipeline: stage 1 locates the card, stage 2 issues font_addr (the ROM
// answers during the next cycle), stage 3 registers pixel_data, giving a
// fixed three-cycle latency from x_pos/y_pos.
// Game state is snapshotted on frame_start so an image never tears.
// Optional build macro PAGE_GAME_BLINK_EN: blink the cursor 16 frames on,
// 16 frames off using a 5-bit frame counter; otherwise the cursor is steady.
module page_game_grid
  import page_game_pkg::*;
#(
  parameter int ROWS      = 2,
  parameter int COLS_MAX  = 5,
  parameter int CELL_W    = 80,
  parameter int CELL_H    = 128,
  parameter int ROW_Y0    = 150,
  parameter int ROW_PITCH = 180
) (
  input logic       vga_clk,
  input logic       vga_rst_n,
  page_game_if.slave bus
);
  localparam int NCARD  = ROWS * COLS_MAX;
  localparam int TN_W   = $clog2(COLS_MAX + 1);
  localparam int CP_W   = clog2_min1(ROWS);
  localparam int GE_W   = $clog2(ROWS + 1);
  localparam int RW     = clog2_min1(ROWS);
  localparam int CW     = clog2_min1(COLS_MAX);
  localparam int DX_W   = clog2_min1(CELL_W);
  localparam int DY_W   = clog2_min1(CELL_H);
  localparam int WIN_LO = GLYPH_MARGIN;
  localparam int WIN_HI = CELL_W - 1 - GLYPH_MARGIN;

  // ---------------- frame snapshot ----------------
  logic [TN_W-1:0]    snap_total;
  logic [CP_W-1:0]    snap_cur;
  logic               snap_selecting;
  logic [7:0]         snap_cur_sel;
  logic [7:0]         snap_sel;
  logic [GE_W-1:0]    snap_ge;
  logic [NCARD*4-1:0] snap_status;

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      snap_total     <= '0;
      snap_cur       <= '0;
      snap_selecting <= 1'b0;
      snap_cur_sel   <= '0;
      snap_sel       <= '0;
      snap_ge        <= '0;
      snap_status    <= '0;
    end else if (bus.frame_start) begin
      snap_total     <= bus.total_number;
      snap_cur       <= bus.cur_player;
      snap_selecting <= bus.selecting;
      snap_cur_sel   <= bus.cur_select;
      snap_sel       <= bus.selected;
      snap_ge        <= bus.game_end;
      snap_status    <= bus.status;
    end
  end

  // ---------------- cursor blink ----------------
  logic cursor_on;

`ifdef PAGE_GAME_BLINK_EN
  logic [4:0] frame_cnt;

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) frame_cnt <= '0;
    else if (bus.frame_start) frame_cnt <= frame_cnt + 5'd1;
  end

  assign cursor_on = ~frame_cnt[4];
`else
  assign cursor_on = 1'b1;
`endif

  // ---------------- stage 1: locate ----------------
  logic [TN_W-1:0] n_clamp;
  logic            loc_hit;
  logic [RW-1:0]   loc_row;
  logic [CW-1:0]   loc_col;
  logic [DX_W-1:0] loc_dx;
  logic [DY_W-1:0] loc_dy;

  assign n_clamp = (int'(snap_total) > COLS_MAX) ? TN_W'(COLS_MAX) : snap_total;

  page_game_cell_locate #(
    .ROWS(ROWS), .COLS_MAX(COLS_MAX), .CELL_W(CELL_W), .CELL_H(CELL_H),
    .ROW_Y0(ROW_Y0), .ROW_PITCH(ROW_PITCH)
  ) u_locate (
    .x(bus.x_pos), .y(bus.y_pos), .n(n_clamp),
    .hit(loc_hit), .row(loc_row), .col(loc_col), .dx(loc_dx), .dy(loc_dy)
  );

  logic            s1_vld;
  logic            s1_hit;
  logic [RW-1:0]   s1_row;
  logic [CW-1:0]   s1_col;
  logic [DX_W-1:0] s1_dx;
  logic [DY_W-1:0] s1_dy;

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      s1_vld <= 1'b0;
      s1_hit <= 1'b0;
      s1_row <= '0;
      s1_col <= '0;
      s1_dx  <= '0;
      s1_dy  <= '0;
    end else begin
      s1_vld <= 1'b1;
      s1_hit <= loc_hit;
      s1_row <= loc_row;
      s1_col <= loc_col;
      s1_dx  <= loc_dx;
      s1_dy  <= loc_dy;
    end
  end

  // ---------------- stage 2: fetch ----------------
  int          ki, dxi, dyi, dxc;
  logic [3:0]  digit;
  logic        in_win, border, playing, is_cur, is_sel;
  logic [14:0] addr;
  stage2_t     s2_d, s2_q;

  always_comb begin
    dxi     = int'(s1_dx);
    dyi     = int'(s1_dy);
    ki      = int'(s1_row) * COLS_MAX + int'(s1_col);
    digit   = snap_status[ki*4 +: 4];
    in_win  = (dxi >= WIN_LO) && (dxi <= WIN_HI);
    // Outside the glyph window the column is pinned to the nearest window
    // edge; the ink is masked there so the ROM word is never used.
    dxc     = (dxi < WIN_LO) ? WIN_LO : ((dxi > WIN_HI) ? WIN_HI : dxi);
    // Glyph is stored right-to-left and drawn at 2x in both directions.
    addr    = s1_hit ? 15'(int'(digit) * GLYPH_PITCH + ((WIN_HI - dxc) >> 1)
                           + (dyi >> 1) * ROM_ROW)
                     : '0;
    playing = (int'(snap_ge) == GE_PLAYING);
    // ki is always a valid card, so an out-of-range index never matches.
    is_cur  = (ki == int'(snap_cur_sel));
    is_sel  = snap_selecting && (ki == int'(snap_sel));
    border  = (dxi < BORDER_W) || (dxi >= CELL_W - BORDER_W) ||
              (dyi < BORDER_W) || (dyi >= CELL_H - BORDER_W);

    s2_d.vld = s1_vld;
    s2_d.hit = s1_hit;
    if (ge_row_won(int'(snap_ge), int'(s1_row)))  s2_d.bg = WIN;
    else if (!playing)                            s2_d.bg = BG;
    else if (int'(s1_row) == int'(snap_cur))      s2_d.bg = ACTIVE;
    else                                          s2_d.bg = BG;
    s2_d.ink_en = in_win && (digit <= 4'd9);
    s2_d.ink    = (is_sel && playing) ? SEL : INK;
    s2_d.cursor = border && is_cur && playing && cursor_on;
  end

  assign bus.font_addr = addr;

  // ---------------- stage 3: colour ----------------
  logic [11:0] pixel_q;

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      s2_q    <= '0;
      pixel_q <= '0;
    end else begin
      s2_q <= s2_d;
      if (!s2_q.vld)                          pixel_q <= '0;
      else if (!s2_q.hit)                     pixel_q <= BG;
      else if (s2_q.cursor)                   pixel_q <= CURSOR;
      else if (s2_q.ink_en && bus.font_data)  pixel_q <= s2_q.ink;
      else                                    pixel_q <= s2_q.bg;
    end
  end

  assign bus.pixel_data = pixel_q;

endmodule

// File: tb/tb_page_game_grid.sv
// tb_page_game_grid: self-checking bench for page_game_grid with default
// parameters. A behavioural font ROM answers one cycle after font_addr;
// a reference model computes each expected pixel from the bench's own copy
// of the frame snapshot.
module tb_page_game_grid;

  localparam int ROWS     = 2;
  localparam int COLS_MAX = 5;

  logic        vga_clk;
  logic        vga_rst_n;
  logic [9:0]  x_pos, y_pos;
  logic        frame_start;
  logic [2:0]  total_number;
  logic [0:0]  cur_player;
  logic [39:0] status;
  logic        selecting;
  logic [7:0]  cur_select, selected;
  logic [1:0]  game_end;

  // bench copy of the snapshot
  logic [2:0]  m_total;
  logic [0:0]  m_cur;
  logic        m_selecting;
  logic [7:0]  m_cur_sel, m_sel;
  logic [1:0]  m_ge;
  logic [39:0] m_status;
  logic [4:0]  m_frames;

  int rom_mode;
  int total_cnt;
  int bad_cnt;

  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];
  int          px_q[$];
  int          py_q[$];

  page_game_if #(.ROWS(ROWS), .COLS_MAX(COLS_MAX)) bus_if ();

  assign bus_if.x_pos        = x_pos;
  assign bus_if.y_pos        = y_pos;
  assign bus_if.frame_start  = frame_start;
  assign bus_if.total_number = total_number;
  assign bus_if.cur_player   = cur_player;
  assign bus_if.status       = status;
  assign bus_if.selecting    = selecting;
  assign bus_if.cur_select   = cur_select;
  assign bus_if.selected     = selected;
  assign bus_if.game_end     = game_end;

  page_game_grid #(
    .ROWS(ROWS), .COLS_MAX(COLS_MAX), .CELL_W(80), .CELL_H(128),
    .ROW_Y0(150), .ROW_PITCH(180)
  ) dut (
    .vga_clk(vga_clk),
    .vga_rst_n(vga_rst_n),
    .bus(bus_if)
  );

  // ---------------- clock / reset / ROM ----------------
  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  function automatic logic rom_fn(input logic [14:0] a);
    if (rom_mode == 0) return 1'b0;
    if (rom_mode == 1) return 1'b1;
    return a[0] ^ a[6];
  endfunction

  always @(posedge vga_clk) bus_if.font_data <= rom_fn(bus_if.font_addr);

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [11:0] model_pixel(input int x, input int y);
    int n, left, r, c, dx, dy, k, d, ytop;
    logic [11:0] bgc;
    logic [14:0] a;
    logic con;
    n = (int'(m_total) > 5) ? 5 : int'(m_total);
    left = 320 - 40 * n;
    if (n == 0 || x < left || x >= 320 + 40 * n) return 12'hfff;
    r = -1;
    dy = 0;
    for (int i = 0; i < 2; i++) begin
      ytop = 150 + 180 * i - 64;
      if (y >= ytop && y < ytop + 128) begin
        r = i;
        dy = y - ytop;
      end
    end
    if (r < 0) return 12'hfff;
    c = (x - left) / 80;
    dx = (x - left) % 80;
    k = r * 5 + c;
    d = int'(m_status[k*4 +: 4]);
    if (int'(m_ge) == r + 1)      bgc = 12'hff0;
    else if (m_ge != 0)           bgc = 12'hfff;
    else if (r == int'(m_cur))    bgc = 12'haaa;
    else                          bgc = 12'hfff;
`ifdef PAGE_GAME_BLINK_EN
    con = ~m_frames[4];
`else
    con = 1'b1;
`endif
    if (k == int'(m_cur_sel) && m_ge == 0 && con &&
        (dx < 4 || dx >= 76 || dy < 4 || dy >= 124)) return 12'h00f;
    if (dx >= 8 && dx <= 71 && d <= 9) begin
      a = 15'(d * 32 + ((71 - dx) >> 1) + (dy >> 1) * 320);
      if (rom_fn(a)) return (m_selecting && k == int'(m_sel) && m_ge == 0) ? 12'h0f0 : 12'h000;
    end
    return bgc;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic frame();
    frame_start = 1'b1;
    @(posedge vga_clk); #1;
    frame_start = 1'b0;
    m_total     = total_number;
    m_cur       = cur_player;
    m_selecting = selecting;
    m_cur_sel   = cur_select;
    m_sel       = selected;
    m_ge        = game_end;
    m_status    = status;
    m_frames    = m_frames + 5'd1;
  endtask

  task automatic add_pt(input int x, input int y);
    px_q.push_back(x);
    py_q.push_back(y);
  endtask

  // One coordinate per clock; expected pixels queued as each is driven,
  // DUT output captured three clocks later.
  task automatic drive_stream();
    int n;
    n = px_q.size();
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin
        x_pos = 10'(px_q[i]);
        y_pos = 10'(py_q[i]);
        exp_q.push_back(model_pixel(px_q[i], py_q[i]));
      end
      @(posedge vga_clk); #1;
      if (i >= 2) obs_q.push_back(bus_if.pixel_data);
    end
    px_q.delete();
    py_q.delete();
  endtask

  task automatic set_status_all(input logic [3:0] d);
    for (int k = 0; k < 10; k++) status[k*4 +: 4] = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    vga_rst_n = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
    total_cnt++;
    if (bus_if.pixel_data !== 12'h000) begin
      bad_cnt++;
      $display("FAIL reset_pixel pixel_data=%h expected=000", bus_if.pixel_data);
    end
    total_cnt++;
    if (bus_if.font_addr !== 15'd0) begin
      bad_cnt++;
      $display("FAIL reset_font_addr font_addr=%0d expected=0", bus_if.font_addr);
    end
    vga_rst_n = 1'b1;
    m_frames = '0;
  endtask

  task automatic test_left_edge();
    logic [11:0] e, o;
    int idx;
    total_number = 3'd5;
    set_status_all(4'd7);
    cur_player = 1'b0;
    game_end = 2'd0;
    cur_select = 8'd10;  // first out-of-range index
    selected = 8'd10;
    selecting = 1'b0;
    rom_mode = 2;
    frame();
    x_pos = 10'd120; y_pos = 10'd150;
    repeat (2) @(posedge vga_clk);
    #1;
    total_cnt++;
    if (bus_if.font_addr !== 15'(7 * 32 + 31 + 32 * 320)) begin
      bad_cnt++;
      $display("FAIL left_font_addr font_addr=%0d expected=%0d", bus_if.font_addr, 7 * 32 + 31 + 32 * 320);
    end
    x_pos = 10'd140;
    repeat (2) @(posedge vga_clk);
    #1;
    total_cnt++;
    if (bus_if.font_addr !== 15'(7 * 32 + 25 + 32 * 320)) begin
      bad_cnt++;
      $display("FAIL win_font_addr font_addr=%0d expected=%0d", bus_if.font_addr, 7 * 32 + 25 + 32 * 320);
    end
    add_pt(119, 150); add_pt(120, 150); add_pt(125, 150); add_pt(128, 150);
    add_pt(140, 150); add_pt(157, 170); add_pt(191, 150); add_pt(192, 150);
    add_pt(199, 150); add_pt(200, 150); add_pt(439, 150); add_pt(519, 150);
    add_pt(520, 150); add_pt(320, 85);  add_pt(320, 86);  add_pt(320, 213);
    add_pt(320, 214); add_pt(330, 266); add_pt(345, 393); add_pt(320, 394);
    drive_stream();
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total_cnt++;
      if (o !== e) begin
        bad_cnt++;
        $display("FAIL left_edge_%0d pixel_data=%h expected=%h", idx, o, e);
      end
      idx++;
    end
    // hard-wired anchor: just left of the span is background
    total_cnt++;
    if (model_pixel(119, 150) !== 12'hfff) begin
      bad_cnt++;
      $display("FAIL left_anchor model=%h expected=fff", model_pixel(119, 150));
    end
  endtask

  task automatic test_row_tints();
    logic [11:0] e, o;
    int idx;
    rom_mode = 0;
    idx = 0;
    cur_player = 1'b1;
    cur_select = 8'd2;
    for (int g = 0; g < 3; g++) begin
      game_end = 2'(g);
      frame();
      add_pt(150, 150); add_pt(150, 300); add_pt(282, 150);
      add_pt(320, 150); add_pt(357, 212);
      drive_stream();
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        total_cnt++;
        if (o !== e) begin
          bad_cnt++;
          $display("FAIL tint_%0d pixel_data=%h expected=%h", idx, o, e);
        end
        idx++;
      end
    end
  endtask

  task automatic test_cursor_select();
    logic [11:0] e, o;
    int idx;
    rom_mode = 1;
    idx = 0;
    total_number = 3'd5;
    cur_player = 1'b0;
    game_end = 2'd0;
    cur_select = 8'd6;
    selected = 8'd6;
    set_status_all(4'd3);
    for (int p = 0; p < 4; p++) begin
      selecting = (p != 1);
      if (p == 2) status[6*4 +: 4] = 4'd12;
      if (p == 3) begin
        status[6*4 +: 4] = 4'd3;
        selected = 8'd10;
      end
      frame();
      add_pt(201, 270); add_pt(240, 268); add_pt(278, 300); add_pt(240, 392);
      add_pt(240, 330); add_pt(205, 330); add_pt(160, 330); add_pt(208, 300);
      drive_stream();
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        total_cnt++;
        if (o !== e) begin
          bad_cnt++;
          $display("FAIL cursor_%0d pixel_data=%h expected=%h", idx, o, e);
        end
        idx++;
      end
    end
  endtask

  task automatic test_snapshot_clamp();
    logic [11:0] e, o;
    int idx;
    rom_mode = 0;
    idx = 0;
    cur_player = 1'b0;
    game_end = 2'd0;
    cur_select = 8'd10;
    selecting = 1'b0;
    total_number = 3'd5;
    frame();
    total_number = 3'd3;   // changed mid-frame: must not show yet
    add_pt(120, 150); add_pt(439, 150); add_pt(199, 150);
    drive_stream();
    frame();
    add_pt(199, 150); add_pt(200, 150); add_pt(439, 150); add_pt(440, 150);
    drive_stream();
    total_number = 3'd7;
    frame();
    add_pt(119, 150); add_pt(120, 150); add_pt(519, 150); add_pt(520, 150);
    drive_stream();
    total_number = 3'd0;
    frame();
    add_pt(320, 150); add_pt(300, 300);
    drive_stream();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total_cnt++;
      if (o !== e) begin
        bad_cnt++;
        $display("FAIL snapshot_%0d pixel_data=%h expected=%h", idx, o, e);
      end
      idx++;
    end
  endtask

  task automatic test_reset_mid();
    total_number = 3'd5;
    cur_player = 1'b1;
    rom_mode = 0;
    frame();
    x_pos = 10'd320; y_pos = 10'd150;
    repeat (3) @(posedge vga_clk);
    #2;
    vga_rst_n = 1'b0;
    m_total = '0; m_cur = '0; m_selecting = 1'b0; m_cur_sel = '0;
    m_sel = '0; m_ge = '0; m_status = '0; m_frames = '0;
    #1;
    total_cnt++;
    if (bus_if.pixel_data !== 12'h000) begin
      bad_cnt++;
      $display("FAIL rst_mid_pixel pixel_data=%h expected=000", bus_if.pixel_data);
    end
    total_cnt++;
    if (bus_if.font_addr !== 15'd0) begin
      bad_cnt++;
      $display("FAIL rst_mid_font_addr font_addr=%0d expected=0", bus_if.font_addr);
    end
    @(posedge vga_clk); #1;
    vga_rst_n = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      @(posedge vga_clk); #1;
      total_cnt++;
      if (j < 3 && bus_if.pixel_data !== 12'h000) begin
        bad_cnt++;
        $display("FAIL rst_release_%0d pixel_data=%h expected=000", j, bus_if.pixel_data);
      end else if (j == 3 && bus_if.pixel_data !== model_pixel(320, 150)) begin
        bad_cnt++;
        $display("FAIL rst_release_3 pixel_data=%h expected=%h", bus_if.pixel_data, model_pixel(320, 150));
      end
    end
  endtask

  task automatic test_blink();
    logic [11:0] e, o;
    int fr;
    rom_mode = 0;
    total_number = 3'd5;
    cur_player = 1'b1;
    game_end = 2'd0;
    cur_select = 8'd0;
    selecting = 1'b0;
    for (int f = 0; f < 34; f++) begin
      if (f > 0) frame();
      else begin
        // first pass uses the post-reset snapshot (no cards) to see frame 0
        total_number = 3'd5;
      end
      fr = int'(m_frames);
      add_pt(121, 150); add_pt(160, 88);
      drive_stream();
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        total_cnt++;
        if (o !== e) begin
          bad_cnt++;
          $display("FAIL blink_frame%0d pixel_data=%h expected=%h", fr, o, e);
        end
      end
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    total_cnt = 0;
    bad_cnt = 0;
    rom_mode = 0;
    x_pos = '0; y_pos = '0; frame_start = 1'b0;
    total_number = '0; cur_player = '0; status = '0; selecting = 1'b0;
    cur_select = '0; selected = '0; game_end = '0;
    m_total = '0; m_cur = '0; m_selecting = 1'b0; m_cur_sel = '0;
    m_sel = '0; m_ge = '0; m_status = '0; m_frames = '0;
    test_reset();
    test_left_edge();
    test_row_tints();
    test_cursor_select();
    test_snapshot_clamp();
    test_reset_mid();
    test_blink();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
